// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end sharing one external combinational ALU between two requesters.
// Latency: response valid two cycles after accept (one cycle for an illegal selector); one op in flight.
// Backpressure: req_ready only while IDLE; the response is held until the owner's rsp_ready.
module alu_arbiter #(
  parameter logic [3:0] OP_MAX = 4'h9,
  parameter int         CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  input  logic [3:0]       req0_sel,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  input  logic [3:0]       req1_sel,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [7:0]       rsp_result,
  output logic [3:0]       rsp_nzvc,
  output logic             rsp_err,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_result,
  input  logic [3:0]       alu_nzvc,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  logic       ptr;
  logic       owner;
  logic       gnt;
  logic       accept;
  logic       rsp_done;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [3:0] sel_q;
  logic [7:0] acc_a;
  logic [7:0] acc_b;
  logic [3:0] acc_sel;

  // The ALU only ever sees the latched operands, never the live request inputs.
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_sel = sel_q;

  // Grant selection: contested requests follow the pointer, otherwise the sole requester wins.
  always_comb begin
    gnt       = (req_valid == 2'b11) ? ptr : req_valid[1];
    accept    = rst_n && (state == IDLE) && (req_valid != 2'b00);
    req_ready = 2'b00;
    if (accept) begin
      req_ready[gnt] = 1'b1;
    end
    acc_a    = gnt ? req1_a   : req0_a;
    acc_b    = gnt ? req1_b   : req0_b;
    acc_sel  = gnt ? req1_sel : req0_sel;
    rsp_done = (state == RESP) && (owner ? rsp_ready[1] : rsp_ready[0]);
  end

  // Control FSM: accept in IDLE, one ALU cycle in EXEC, hold the response in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      owner      <= 1'b0;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      sel_q      <= 4'h0;
      rsp_result <= 8'h00;
      rsp_nzvc   <= 4'h0;
      rsp_err    <= 1'b0;
      rsp_valid  <= 2'b00;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner <= gnt;
            ptr   <= ~gnt;
            a_q   <= acc_a;
            b_q   <= acc_b;
            sel_q <= acc_sel;
            busy  <= 1'b1;
            if (acc_sel > OP_MAX) begin
              // Illegal selector skips the ALU and answers with a zeroed error response.
              state      <= RESP;
              rsp_result <= 8'h00;
              rsp_nzvc   <= 4'h0;
              rsp_err    <= 1'b1;
              rsp_valid  <= gnt ? 2'b10 : 2'b01;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_nzvc   <= alu_nzvc;
          rsp_err    <= ((sel_q == 4'd3) || (sel_q == 4'd4)) && (b_q == 8'h00);
          rsp_valid  <= owner ? 2'b10 : 2'b01;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Completed-response counters, both saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count  <= '0;
      err_count <= 8'h00;
    end else if (rsp_done) begin
      if (op_count != {CNT_W{1'b1}}) begin
        op_count <= op_count + 1'b1;
      end
      if (rsp_err && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'h01;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus against alu_arbiter with a stub ALU and a transaction-level model.
// Latency: model predicts accept, response timing (2 or 1 cycles) and counters from inputs only.
// Backpressure: response stalls, non-owner ready and dropped requests are exercised directly.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_sel, req1_sel;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [7:0]  rsp_result;
  logic [3:0]  rsp_nzvc;
  logic        rsp_err;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_result;
  logic [3:0]  alu_nzvc;
  logic        busy;
  logic [15:0] op_count;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.OP_MAX(4'h9), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_nzvc(rsp_nzvc), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_nzvc(alu_nzvc),
    .busy(busy), .op_count(op_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: {result, N, Z, V, C}; divide/modulo by zero returns all ones.
  function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    logic [8:0] w;
    logic [7:0] r;
    logic v, c;
    w = 9'h000; r = 8'h00; v = 1'b0; c = 1'b0;
    case (s)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd1: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd2: r = a & b;
      4'd3: begin if (b == 8'h00) return {8'hFF, 4'hF}; r = a / b; end
      4'd4: begin if (b == 8'h00) return {8'hFF, 4'hF}; r = a % b; end
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: r = {a[6:0], 1'b0};
      4'd8: r = {1'b0, a[7:1]};
      default: r = a;
    endcase
    return {r, r[7], (r == 8'h00), v, c};
  endfunction

  always_comb {alu_result, alu_nzvc} = alu_ref(alu_a, alu_b, alu_sel);

  function automatic logic grant_of(input logic [1:0] v, input logic p);
    return (v == 2'b11) ? p : v[1];
  endfunction

  // Transaction-level model state.
  logic       m_busy = 1'b0, m_ptr = 1'b0, m_owner = 1'b0, m_err = 1'b0;
  logic [7:0] m_a = 8'h00, m_b = 8'h00, m_res = 8'h00;
  logic [3:0] m_sel = 4'h0, m_nzvc = 4'h0;
  int         m_wait = 0, m_ops = 0, m_errs = 0;

  logic        pg;
  logic [7:0]  pa, pb;
  logic [3:0]  ps;
  logic [11:0] pres;
  logic        pill;
  assign pg   = grant_of(req_valid, m_ptr);
  assign pa   = pg ? req1_a : req0_a;
  assign pb   = pg ? req1_b : req0_b;
  assign ps   = pg ? req1_sel : req0_sel;
  assign pres = alu_ref(pa, pb, ps);
  assign pill = (ps > 4'h9);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_ptr <= 1'b0; m_wait <= 0; m_ops <= 0; m_errs <= 0;
    end else if (m_busy) begin
      if (m_wait != 0) m_wait <= m_wait - 1;
      else if (rsp_ready[m_owner]) begin
        m_busy <= 1'b0;
        if (m_ops < 65535) m_ops <= m_ops + 1;
        if (m_err && m_errs < 255) m_errs <= m_errs + 1;
      end
    end else if (req_valid != 2'b00) begin
      m_busy  <= 1'b1;
      m_owner <= pg;
      m_ptr   <= ~pg;
      m_a <= pa; m_b <= pb; m_sel <= ps;
      m_res   <= pill ? 8'h00 : pres[11:4];
      m_nzvc  <= pill ? 4'h0 : pres[3:0];
      m_err   <= pill || (((ps == 4'd3) || (ps == 4'd4)) && (pb == 8'h00));
      m_wait  <= pill ? 0 : 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of DUT outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("mon_busy", {31'd0, busy}, {31'd0, m_busy});
      if (m_busy || req_valid == 2'b00) chk("mon_req_ready", {30'd0, req_ready}, 32'd0);
      else chk("mon_req_ready", {30'd0, req_ready}, grant_of(req_valid, m_ptr) ? 32'd2 : 32'd1);
      if (m_busy && m_wait == 0) begin
        chk("mon_rsp_valid", {30'd0, rsp_valid}, m_owner ? 32'd2 : 32'd1);
        chk("mon_rsp_result", {24'd0, rsp_result}, {24'd0, m_res});
        chk("mon_rsp_nzvc", {28'd0, rsp_nzvc}, {28'd0, m_nzvc});
        chk("mon_rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
      end else begin
        chk("mon_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      end
      if (m_busy) begin
        chk("mon_alu_ops", {12'd0, alu_a, alu_b, alu_sel}, {12'd0, m_a, m_b, m_sel});
      end
      chk("mon_op_count", {16'd0, op_count}, m_ops);
      chk("mon_err_count", {24'd0, err_count}, m_errs);
    end
  end

  task automatic issue(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] b0, input logic [3:0] s0,
                       input logic [7:0] a1, input logic [7:0] b1, input logic [3:0] s1, input bit hold);
    req_valid = v;
    req0_a = a0; req0_b = b0; req0_sel = s0;
    req1_a = a1; req1_b = b1; req1_sel = s1;
    @(posedge clk); #1;
    if (!hold) req_valid = 2'b00;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic finish_rsp(input logic g);
    @(posedge clk); #1;
    rsp_ready = g ? 2'b10 : 2'b01;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
  endtask

  int lat;
  bit exp_rr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00;
    req0_a = 8'h00; req0_b = 8'h00; req0_sel = 4'h0;
    req1_a = 8'h00; req1_b = 8'h00; req1_sel = 4'h0;
    #12;
    chk("reset_req_ready", {30'd0, req_ready}, 32'd0);
    chk("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_counts", {8'd0, op_count, err_count}, 32'd0);
    req_valid = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Add with signed overflow from requester 0.
    issue(2'b01, 8'h7F, 8'h01, 4'd0, 8'h00, 8'h00, 4'd0, 1'b0);
    wait_rsp(lat);
    chk("add_latency", lat, 32'd2);
    chk("add_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("add_result", {24'd0, rsp_result}, 32'h80);
    chk("add_nzvc", {28'd0, rsp_nzvc}, 32'hA);
    chk("add_err", {31'd0, rsp_err}, 32'd0);
    finish_rsp(1'b0);
    chk("add_op_count", {16'd0, op_count}, 32'd1);

    // Divide by zero from requester 1.
    issue(2'b10, 8'h00, 8'h00, 4'd0, 8'h10, 8'h00, 4'd3, 1'b0);
    wait_rsp(lat);
    chk("div0_latency", lat, 32'd2);
    chk("div0_rsp_valid", {30'd0, rsp_valid}, 32'd2);
    chk("div0_result", {24'd0, rsp_result}, 32'hFF);
    chk("div0_nzvc", {28'd0, rsp_nzvc}, 32'hF);
    chk("div0_err", {31'd0, rsp_err}, 32'd1);
    finish_rsp(1'b1);
    chk("div0_err_count", {24'd0, err_count}, 32'd1);

    // Illegal selector answers one cycle after accept.
    issue(2'b01, 8'h55, 8'h22, 4'hC, 8'h00, 8'h00, 4'd0, 1'b0);
    wait_rsp(lat);
    chk("illegal_latency", lat, 32'd1);
    chk("illegal_result", {24'd0, rsp_result}, 32'h00);
    chk("illegal_nzvc", {28'd0, rsp_nzvc}, 32'h0);
    chk("illegal_err", {31'd0, rsp_err}, 32'd1);
    finish_rsp(1'b0);
    chk("illegal_err_count", {24'd0, err_count}, 32'd2);

    // Response stall; non-owner ready ignored, requests arriving meanwhile are dropped.
    issue(2'b10, 8'h00, 8'h00, 4'd0, 8'h30, 8'h12, 4'd1, 1'b0);
    wait_rsp(lat);
    chk("stall_latency", lat, 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      rsp_ready = 2'b01;
      req_valid = 2'b11;
      @(negedge clk);
      chk("stall_busy", {31'd0, busy}, 32'd1);
      chk("stall_req_ready", {30'd0, req_ready}, 32'd0);
      chk("stall_result", {24'd0, rsp_result, rsp_nzvc}, 32'h1E0);
    end
    @(posedge clk); #1;
    req_valid = 2'b00; rsp_ready = 2'b00;
    finish_rsp(1'b1);
    chk("stall_op_count", {16'd0, op_count}, 32'd4);

    // Both requesters held: grants alternate.
    for (int i = 0; i < 4; i++) begin
      issue(2'b11, 8'(i * 3), 8'h05, 4'd0, 8'(8'h40 + i), 8'h02, 4'd6, 1'b1);
      wait_rsp(lat);
      chk("rr_latency", lat, 32'd2);
      chk("rr_grant", {30'd0, rsp_valid}, exp_rr[i] ? 32'd2 : 32'd1);
      finish_rsp(exp_rr[i]);
    end
    req_valid = 2'b00;

    // Reset during EXEC abandons the operation and restores the pointer.
    issue(2'b01, 8'h11, 8'h22, 4'd0, 8'h00, 8'h00, 4'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_counts", {8'd0, op_count, err_count}, 32'd0);
    chk("rst_rsp_regs", {19'd0, rsp_result, rsp_nzvc, rsp_err}, 32'd0);
    chk("rst_alu_ops", {12'd0, alu_a, alu_b, alu_sel}, 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 2'b11;
    req0_a = 8'h09; req0_b = 8'h03; req0_sel = 4'd3;
    req1_a = 8'h01; req1_b = 8'h01; req1_sel = 4'd0;
    #1;
    chk("post_rst_grant", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_rsp(lat);
    chk("post_rst_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("post_rst_result", {24'd0, rsp_result}, 32'h03);
    finish_rsp(1'b0);
    chk("post_rst_op_count", {16'd0, op_count}, 32'd1);

    // Drive err_count to saturation with illegal selectors.
    for (int i = 0; i < 256; i++) begin
      issue(2'b01, 8'(i), 8'h00, 4'hF, 8'h00, 8'h00, 4'd0, 1'b0);
      wait_rsp(lat);
      finish_rsp(1'b0);
    end
    chk("sat_err_count", {24'd0, err_count}, 32'hFF);
    chk("sat_op_count", {16'd0, op_count}, 32'd257);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: OP_MAX, 4'h9, highest legal ALU selector code.
REQ-002 Parameter: CNT_W, 16, width of completed-operation counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  2  per-requester operation request (bit i = requester i).
REQ-006 req_ready  output  2  per-requester accept; transfer when valid & ready at a rising edge.
REQ-007 req0_a, req0_b  input  8 each  requester-0 operands.
REQ-008 req0_sel  input  4  requester-0 ALU selector.
REQ-009 req1_a, req1_b, req1_sel  input  8/8/4  requester-1 operands and selector.
REQ-010 rsp_valid  output  2  per-requester response valid.
REQ-011 rsp_ready  input  2  per-requester response accept.
REQ-012 rsp_result  output  8  result of completed operation (shared by both requesters).
REQ-013 rsp_nzvc  output  4  N,Z,V,C flags of completed operation.
REQ-014 rsp_err  output  1  illegal selector or divide/modulo by zero.
REQ-015 alu_a, alu_b  output  8 each  operands driven to shared ALU.
REQ-016 alu_sel  output  4  selector driven to shared ALU.
REQ-017 alu_result  input  8  combinational ALU result.
REQ-018 alu_nzvc  input  4  combinational ALU flags.
REQ-019 busy  output  1  high whenever FSM not in IDLE.
REQ-020 op_count  output  CNT_W  saturating count of completed responses.
REQ-021 err_count  output  8  saturating count of responses with rsp_err=1.

Function
REQ-022 FSM states SHALL be IDLE, EXEC, RESP.
REQ-023 IDLE: if any req_valid, grant one requester; req_ready[g]=1 combinationally for granted g only, 0 otherwise; req_ready SHALL be 0 in EXEC and RESP.
REQ-024 Arbitration SHALL be round-robin: priority pointer starts at requester 0; after each grant the pointer moves to the other requester; sole valid requester always wins.
REQ-025 On accept edge, operands/selector of g SHALL be latched into operand registers and g latched as owner.
REQ-026 Accept with latched sel <= OP_MAX: IDLE -> EXEC; sel > OP_MAX: IDLE -> RESP directly with rsp_result=8'h00, rsp_nzvc=4'h0, rsp_err=1.
REQ-027 alu_a/alu_b/alu_sel SHALL always reflect operand registers (no combinational path from req inputs).
REQ-028 EXEC lasts exactly one cycle; at its end alu_result and alu_nzvc SHALL be captured into rsp_result/rsp_nzvc; state -> RESP.
REQ-029 rsp_err SHALL be 1 when captured sel is 3 or 4 and latched B == 0, else 0; ALU-returned result/flags still reported unmodified.
REQ-030 Latency: rsp_valid asserted in second cycle after accept edge for legal ops, first cycle after accept for illegal ops.
REQ-031 RESP: rsp_valid[owner]=1, other bit 0; rsp_result/nzvc/err held stable until rsp_ready[owner] sampled high; then -> IDLE.
REQ-032 rsp_ready of the non-owner SHALL be ignored.
REQ-033 No new request accepted in the cycle the response completes (next accept earliest one cycle after return to IDLE).
REQ-034 op_count SHALL increment by 1 on each response handshake, saturating at all-ones; err_count increments when rsp_err=1, saturating at 8'hFF.
REQ-035 Requester dropping req_valid before grant SHALL NOT be granted; no request is queued.

Reset
REQ-036 rst_n low SHALL immediately force state IDLE, pointer to requester 0, operand registers, rsp_result, rsp_nzvc, rsp_err, op_count, err_count to 0; req_ready and rsp_valid 0; busy 0.
REQ-037 Reset mid-operation SHALL abandon the in-flight operation with no response and no counter update.

Verification
REQ-038 Req0 valid a=8'h7F b=8'h01 sel=0 -> rsp_valid[0] two cycles after accept, result 8'h80, nzvc 4'b1010, err 0, op_count 1.
REQ-039 Both valid simultaneously, held -> grants alternate 0,1,0,1 across four ops; rsp_valid never on wrong bit.
REQ-040 Req1 sel=3 a=8'h10 b=8'h00 -> result 8'hFF, nzvc 4'hF, err 1, err_count 1.
REQ-041 Req0 sel=4'hC -> rsp_valid one cycle after accept, result 8'h00, nzvc 0, err 1, alu_sel never issued via EXEC.
REQ-042 rsp_ready held low 5 cycles during RESP -> outputs stable, req_ready 0, busy 1; then handshake -> IDLE.
REQ-043 rst_n asserted during EXEC -> all outputs 0 asynchronously; after release no rsp_valid, counters 0, next grant to requester 0.
